cla64_burst_accumulator: RTL
============================

Name: cla64_burst_accumulator

Overview:
- Registered accumulate stage that sits directly in front of the 64-bit carry-lookahead adder `sixtyfourbitscarrylookaheadadder`.
- Accepts a handshaked stream of 64-bit operands and adds or subtracts each one into an accumulator using a single instance of that adder.
- After every BURST_LEN accepted operands it emits the burst total on a valid/ready output, with carry and signed-overflow flags.
- Feeds downstream consumers of burst sums (checksum/sum-of-terms paths).

Parameters:
- BURST_LEN, 8, operands per result; legal range 1..65535.
- CNT_W, 16, width of the internal beat counter; must satisfy 2^CNT_W > BURST_LEN-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  stage can accept an operand this cycle.
- in_data  input  64  operand.
- in_sub  input  1  1 = subtract in_data, 0 = add; sampled with in_data.
- clr  input  1  synchronous abandon of the current burst.
- out_valid  output  1  burst result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  64  burst total.
- out_cout  output  1  adder cout of the final beat of the burst.
- out_ovf  output  1  sticky signed overflow across the burst.
- beat_cnt  output  CNT_W  beats accepted in the current burst.

Behaviour:
- Reset (rst=1 at a clock edge):
  - acc, beat_cnt, ovf_sticky, out_sum, out_cout, out_ovf and out_valid all become 0.
  - Reset overrides every other input, including mid-burst and with a result pending; the pending result is lost.
- in_ready = !clr && !(out_valid && !out_ready). It is combinational and does not depend on in_valid.
- Accept = in_valid && in_ready.
- Adder connection (one adder instance, combinational):
  - a = acc
  - b = in_sub ? ~in_data : in_data
  - cin = in_sub
  - Result is sum[63:0] and cout. Arithmetic is two's complement, modulo 2^64.
- Per-beat signed overflow: v = (acc[63] == b[63]) && (sum[63] != acc[63]).
- On an accept with beat_cnt < BURST_LEN-1:
  - acc <= sum
  - beat_cnt <= beat_cnt+1
  - ovf_sticky <= ovf_sticky | v
- On an accept with beat_cnt == BURST_LEN-1 (final beat):
  - out_sum <= sum
  - out_cout <= cout
  - out_ovf <= ovf_sticky | v
  - out_valid <= 1
  - acc, beat_cnt and ovf_sticky <= 0
  - Latency: the result is visible the cycle after the final-beat accept.
  - BURST_LEN=1 means every accept produces a result.
- Output handshake:
  - out_valid clears on a cycle with out_valid && out_ready, unless a final-beat accept occurs in that same cycle, in which case the new result loads and out_valid stays 1. This gives back-to-back bursts with no bubble.
  - While out_valid && !out_ready, out_sum, out_cout and out_ovf hold stable and in_ready=0; every beat stalls, including non-final ones.
- clr=1 (rst=0):
  - in_ready=0, so no operand is accepted that cycle.
  - acc, beat_cnt and ovf_sticky <= 0.
  - out_valid, out_sum, out_cout and out_ovf are unaffected, and a pending result can still drain that cycle.
- in_valid=0 or a stall: all state holds.
- beat_cnt never exceeds BURST_LEN-1.
- in_data/in_sub while not accepted: don't-care.
- Sequential state: acc, beat_cnt, ovf_sticky, output registers. Single implicit FSM:
  - ACCUM: out_valid=0.
  - HOLD: out_valid=1. HOLD->ACCUM on drain without a new final beat.
  - ACCUM->HOLD on a final-beat accept.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, out_sum=0, out_cout=0, out_ovf=0, beat_cnt=0, in_ready=1; no beat accepted.
- BURST_LEN=4, out_ready=1, add 1,2,3,4 on consecutive cycles -> beat_cnt 0,1,2,3. One cycle after the 4th accept: out_valid=1 for one cycle, out_sum=10, out_cout=0, out_ovf=0. beat_cnt=0 on that same cycle.
- Add 5, sub 7, add 0, add 0 -> out_sum=0xFFFFFFFFFFFFFFFE, out_ovf=0. Then burst sub 1 ×4 -> out_sum=0xFFFFFFFFFFFFFFFC, out_cout=1.
- Add 0x7FFFFFFFFFFFFFFF, add 1, add 0, add 0 -> out_sum=0x8000000000000000, out_ovf=1 (sticky from beat 2), out_cout=0. Next burst of 1,1,1,1 -> out_ovf=0, out_sum=4.
- Backpressure: out_ready=0, complete a burst summing to 10, then drive in_valid=1 continuously -> in_ready=0, out_sum=10 stable for 5 cycles, no beats counted. Raise out_ready with the next burst's beats already presented -> next result loads with no lost or duplicated beats. Final beat coincident with drain -> out_valid stays 1, new sum appears.
- Abort: after 2 beats (1,1), pulse clr with in_valid=1 -> that beat is not accepted and beat_cnt=0. Then beats 2,2,2,2 -> out_sum=8. Repeat with rst mid-burst after 3 beats -> out_valid=0, next full burst sums only the post-reset beats.

Source files
------------

// File: rtl/cla64_burst_accumulator_if.sv
// Operand stream in, burst-total stream out, for cla64_burst_accumulator.
// The master side drives operands and result-ready; the slave side is the accumulator.
interface cla64_burst_accumulator_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             in_sub;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    output in_valid, in_data, in_sub, clr, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, beat_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sub, clr, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, beat_cnt
  );
endinterface

// File: rtl/cla64_burst_accumulator.sv
// Burst accumulator: adds/subtracts BURST_LEN operands through one 64-bit CLA adder
// and presents the total with carry and sticky signed-overflow on a valid/ready output.
//
// state | meaning
// ACCUM | no result pending (out_valid=0), collecting beats
// HOLD  | result pending (out_valid=1), waiting for out_ready

module sixtyfourbitscarrylookaheadadder (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  // Three lookahead levels: bits within 4-bit groups, groups within blocks, blocks.
  function automatic logic [3:0] la4(input logic [3:0] g, input logic [3:0] p, input logic c0);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  function automatic logic gen4(input logic [3:0] g, input logic [3:0] p);
    logic [3:0] c;
    c = la4(g, p, 1'b0);
    return c[3];
  endfunction

  logic [63:0] g_bit, p_bit, bit_c;
  logic [15:0] grp_g, grp_p, grp_cin;
  logic [3:0]  blk_g, blk_p, blk_c, blk_cin;
  logic [3:0]  gc, bc;

  always_comb begin
    g_bit   = a & b;
    p_bit   = a ^ b;
    grp_g   = '0;
    grp_p   = '0;
    grp_cin = '0;
    blk_g   = '0;
    blk_p   = '0;
    bit_c   = '0;
    gc      = '0;
    bc      = '0;
    for (int j = 0; j < 16; j++) begin
      grp_g[j] = gen4(g_bit[4*j +: 4], p_bit[4*j +: 4]);
      grp_p[j] = &p_bit[4*j +: 4];
    end
    for (int k = 0; k < 4; k++) begin
      blk_g[k] = gen4(grp_g[4*k +: 4], grp_p[4*k +: 4]);
      blk_p[k] = &grp_p[4*k +: 4];
    end
    blk_c   = la4(blk_g, blk_p, cin);
    blk_cin = {blk_c[2:0], cin};
    for (int k = 0; k < 4; k++) begin
      gc = la4(grp_g[4*k +: 4], grp_p[4*k +: 4], blk_cin[k]);
      grp_cin[4*k +: 4] = {gc[2:0], blk_cin[k]};
    end
    for (int j = 0; j < 16; j++) begin
      bc = la4(g_bit[4*j +: 4], p_bit[4*j +: 4], grp_cin[j]);
      bit_c[4*j +: 4] = {bc[2:0], grp_cin[j]};
    end
    sum  = p_bit ^ bit_c;
    cout = blk_c[3];
  end
endmodule

module cla64_burst_accumulator #(
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  cla64_burst_accumulator_if.slave      bus
);
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [63:0]      out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q, out_ovf_d;

  logic [63:0] add_b, add_sum;
  logic        add_cout, beat_ovf, in_ready, accept, last_beat;

  assign add_b = bus.in_sub ? ~bus.in_data : bus.in_data;

  sixtyfourbitscarrylookaheadadder u_adder (
    .a    (acc_q),
    .b    (add_b),
    .cin  (bus.in_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign beat_ovf  = (acc_q[63] == add_b[63]) && (add_sum[63] != acc_q[63]);
  assign in_ready  = !bus.clr && !((state_q == HOLD) && !bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign last_beat = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    out_sum_d    = out_sum_q;
    out_cout_d   = out_cout_q;
    out_ovf_d    = out_ovf_q;

    if ((state_q == HOLD) && bus.out_ready) state_d = ACCUM;

    if (bus.clr) begin
      acc_d        = '0;
      beat_cnt_d   = '0;
      ovf_sticky_d = 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        // A final beat landing on a drain cycle reloads the output: no bubble.
        out_sum_d    = add_sum;
        out_cout_d   = add_cout;
        out_ovf_d    = ovf_sticky_q | beat_ovf;
        state_d      = HOLD;
        acc_d        = '0;
        beat_cnt_d   = '0;
        ovf_sticky_d = 1'b0;
      end else begin
        acc_d        = add_sum;
        beat_cnt_d   = beat_cnt_q + CNT_W'(1);
        ovf_sticky_d = ovf_sticky_q | beat_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      beat_cnt_q   <= '0;
      ovf_sticky_q <= 1'b0;
      out_sum_q    <= '0;
      out_cout_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
      out_sum_q    <= out_sum_d;
      out_cout_q   <= out_cout_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.beat_cnt  = beat_cnt_q;
endmodule
